// File: rtl/video_timing_detector.sv
// Measures incoming video timing (line/frame totals and active sizes), generates
// active-area coordinates, and locks once consecutive frames measure identically.
module video_timing_detector #(
   parameter int H_RES       = 1280,
   parameter int V_RES       = 720,
   parameter int H_POL       = 1,
   parameter int V_POL       = 1,
   parameter int LOCK_FRAMES = 2,
   parameter int TIMEOUT     = 4096
) (
   input  logic        i_pix_clk,
   input  logic        i_rst,
   input  logic        i_hs,
   input  logic        i_vs,
   input  logic        i_de,
   output logic        o_de,
   output logic [15:0] o_sx,
   output logic [15:0] o_sy,
   output logic        o_frame,
   output logic [15:0] o_h_total,
   output logic [15:0] o_h_active,
   output logic [15:0] o_v_total,
   output logic [15:0] o_v_active,
   output logic        o_locked,
   output logic        o_mode_ok,
   output logic        o_err
);

   localparam logic        HP      = (H_POL != 0);
   localparam logic        VP      = (V_POL != 0);
   localparam logic [16:0] TO      = 17'(TIMEOUT);
   localparam logic [15:0] HRES    = 16'(H_RES);
   localparam logic [15:0] VRES    = 16'(V_RES);
   // match_cnt counts frames equal to their predecessor, so LOCK_FRAMES
   // identical frames in a row means LOCK_FRAMES-1 matches.
   localparam logic [7:0]  LOCK_M  = 8'(LOCK_FRAMES - 1);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic        hs_prev_q, vs_prev_q, de_q, frame_q;
   logic [15:0] h_cnt_q, h_cnt_d, line_len_q, line_len_d;
   logic [15:0] de_run_q, de_run_d, line_active_q, line_active_d;
   logic [15:0] v_total_q, v_total_d, v_active_q, v_active_d;
   logic [15:0] sx_q, sx_d, sy_q, sy_d;
   logic [15:0] h_total_q, h_active_q, v_tot_out_q, v_act_out_q;
   logic [7:0]  match_q;
   logic        err_q;
   state_t      state_q;

   logic hs_lead, vs_lead, de_fall, timeout, meas_match;

   // Previous-sample flags hold "was active", so reset leaves them inactive.
   assign hs_lead    = (i_hs == HP) & ~hs_prev_q;
   assign vs_lead    = (i_vs == VP) & ~vs_prev_q;
   assign de_fall    = ~i_de & de_q;
   assign timeout    = {1'b0, h_cnt_q} >= TO;
   assign meas_match = (line_len_q == h_total_q) && (line_active_q == h_active_q) &&
                       (v_total_q == v_tot_out_q) && (v_active_q == v_act_out_q);

   always_comb begin
      h_cnt_d       = hs_lead ? 16'd0 : sat_inc(h_cnt_q);
      line_len_d    = hs_lead ? sat_inc(h_cnt_q) : line_len_q;
      de_run_d      = de_fall ? 16'd0 : (i_de ? sat_inc(de_run_q) : de_run_q);
      line_active_d = de_fall ? de_run_q : line_active_q;
      // A sync edge coinciding with vs belongs to the new frame.
      if (vs_lead) begin
         v_total_d  = {15'd0, hs_lead};
         v_active_d = {15'd0, de_fall};
      end else begin
         v_total_d  = hs_lead ? sat_inc(v_total_q) : v_total_q;
         v_active_d = de_fall ? sat_inc(v_active_q) : v_active_q;
      end
      sx_d = (i_de & de_q) ? sat_inc(sx_q) : 16'd0;
      sy_d = vs_lead ? 16'd0 : (de_fall ? sat_inc(sy_q) : sy_q);
   end

   always_ff @(posedge i_pix_clk or posedge i_rst) begin
      if (i_rst) begin
         hs_prev_q     <= 1'b0;
         vs_prev_q     <= 1'b0;
         de_q          <= 1'b0;
         frame_q       <= 1'b0;
         h_cnt_q       <= '0;
         line_len_q    <= '0;
         de_run_q      <= '0;
         line_active_q <= '0;
         v_total_q     <= '0;
         v_active_q    <= '0;
         sx_q          <= '0;
         sy_q          <= '0;
      end else begin
         hs_prev_q     <= (i_hs == HP);
         vs_prev_q     <= (i_vs == VP);
         de_q          <= i_de;
         frame_q       <= vs_lead;
         h_cnt_q       <= h_cnt_d;
         line_len_q    <= line_len_d;
         de_run_q      <= de_run_d;
         line_active_q <= line_active_d;
         v_total_q     <= v_total_d;
         v_active_q    <= v_active_d;
         sx_q          <= sx_d;
         sy_q          <= sy_d;
      end
   end

   always_ff @(posedge i_pix_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= SEARCH;
         match_q     <= '0;
         err_q       <= 1'b0;
         h_total_q   <= '0;
         h_active_q  <= '0;
         v_tot_out_q <= '0;
         v_act_out_q <= '0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            SEARCH: begin
               if (vs_lead) begin
                  state_q <= MEASURE;
                  match_q <= '0;
               end
            end
            MEASURE: begin
               if (timeout) begin
                  state_q <= SEARCH;
               end else if (vs_lead) begin
                  h_total_q   <= line_len_q;
                  h_active_q  <= line_active_q;
                  v_tot_out_q <= v_total_q;
                  v_act_out_q <= v_active_q;
                  if (meas_match) begin
                     match_q <= match_q + 8'd1;
                     if (match_q + 8'd1 >= LOCK_M) state_q <= LOCKED;
                  end else begin
                     match_q <= '0;
                  end
               end
            end
            LOCKED: begin
               if (timeout) begin
                  state_q <= SEARCH;
                  err_q   <= 1'b1;
               end else if (vs_lead) begin
                  h_total_q   <= line_len_q;
                  h_active_q  <= line_active_q;
                  v_tot_out_q <= v_total_q;
                  v_act_out_q <= v_active_q;
                  if (!meas_match) begin
                     state_q <= SEARCH;
                     err_q   <= 1'b1;
                  end
               end
            end
            default: state_q <= SEARCH;
         endcase
      end
   end

   assign o_de       = de_q;
   assign o_sx       = sx_q;
   assign o_sy       = sy_q;
   assign o_frame    = frame_q;
   assign o_h_total  = h_total_q;
   assign o_h_active = h_active_q;
   assign o_v_total  = v_tot_out_q;
   assign o_v_active = v_act_out_q;
   assign o_locked   = (state_q == LOCKED);
   assign o_mode_ok  = o_locked && (h_active_q == HRES) && (v_act_out_q == VRES);
   assign o_err      = err_q;

endmodule

// File: tb/tb_video_timing_detector.sv
// Bench for video_timing_detector: a reduced raster (40x12 total, 24x8 active)
// keeps runtime short; a second instance sees the same raster with inverted syncs.
module tb_video_timing_detector;

   localparam int HT = 40, HA = 24, VT = 12, VA = 8;

   logic clk, rst, hs, vs, de, hs2, vs2;
   logic        o_de, o_frame, o_locked, o_mode_ok, o_err;
   logic [15:0] o_sx, o_sy, o_h_total, o_h_active, o_v_total, o_v_active;
   logic        p_de, p_frame, p_locked, p_mode_ok, p_err;
   logic [15:0] p_sx, p_sy, p_h_total, p_h_active, p_v_total, p_v_active;

   int checks = 0, errors = 0;
   int vs_cnt, err_cnt, err2_cnt, lock_vs, lock2_vs;
   bit lock_seen, lock2_seen;

   video_timing_detector #(.H_RES(HA), .V_RES(VA), .H_POL(1), .V_POL(1)) dut (
      .i_pix_clk(clk), .i_rst(rst), .i_hs(hs), .i_vs(vs), .i_de(de),
      .o_de(o_de), .o_sx(o_sx), .o_sy(o_sy), .o_frame(o_frame),
      .o_h_total(o_h_total), .o_h_active(o_h_active), .o_v_total(o_v_total),
      .o_v_active(o_v_active), .o_locked(o_locked), .o_mode_ok(o_mode_ok), .o_err(o_err));

   video_timing_detector #(.H_RES(HA), .V_RES(VA), .H_POL(0), .V_POL(0)) dut_n (
      .i_pix_clk(clk), .i_rst(rst), .i_hs(hs2), .i_vs(vs2), .i_de(de),
      .o_de(p_de), .o_sx(p_sx), .o_sy(p_sy), .o_frame(p_frame),
      .o_h_total(p_h_total), .o_h_active(p_h_active), .o_v_total(p_v_total),
      .o_v_active(p_v_active), .o_locked(p_locked), .o_mode_ok(p_mode_ok), .o_err(p_err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        hs, vs, de;
      logic        e_de, e_fr;
      logic [15:0] e_sx, e_sy;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Inputs change just after a rising edge; outputs are read 1 ns after the capturing edge.
   task automatic step(input logic h, input logic v, input logic d);
      hs = h; vs = v; de = d; hs2 = ~h; vs2 = ~v;
      @(posedge clk); #1;
      if (o_frame) vs_cnt++;
      if (o_err) err_cnt++;
      if (p_err) err2_cnt++;
      if (o_locked && !lock_seen) begin lock_seen = 1; lock_vs = vs_cnt; end
      if (p_locked && !lock2_seen) begin lock2_seen = 1; lock2_vs = vs_cnt; end
   endtask

   task automatic clr_mon();
      vs_cnt = 0; err_cnt = 0; err2_cnt = 0; lock_vs = 0; lock2_vs = 0;
      lock_seen = 0; lock2_seen = 0;
   endtask

   task automatic do_reset(input logic vs_held);
      rst = 1'b1; hs = 1'b0; vs = vs_held; de = 1'b0; hs2 = 1'b1; vs2 = ~vs_held;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One raster frame; vs rises with hs at the start of line 10.
   task automatic frame(input int htot, input bit chk_xy);
      for (int ln = 0; ln < VT; ln++)
         for (int x = 0; x < htot; x++) begin
            step(x < 4, ln >= 10, (ln < VA) && (x >= 8) && (x < 8 + HA));
            if (chk_xy && ln == 0 && x == 8) begin
               chk("first_px_sx", o_sx, 0); chk("first_px_sy", o_sy, 0); chk("first_px_de", o_de, 1);
            end
            if (chk_xy && ln == VA - 1 && x == 7 + HA) begin
               chk("last_px_sx", o_sx, HA - 1); chk("last_px_sy", o_sy, VA - 1);
            end
         end
   endtask

   task automatic chk_meas(input string tag);
      chk({tag, "_h_total"}, o_h_total, HT);   chk({tag, "_h_active"}, o_h_active, HA);
      chk({tag, "_v_total"}, o_v_total, VT);   chk({tag, "_v_active"}, o_v_active, VA);
      chk({tag, "_locked"}, o_locked, 1);      chk({tag, "_mode_ok"}, o_mode_ok, 1);
      chk({tag, "_n_h_total"}, p_h_total, HT); chk({tag, "_n_h_active"}, p_h_active, HA);
      chk({tag, "_n_v_total"}, p_v_total, VT); chk({tag, "_n_v_active"}, p_v_active, VA);
      chk({tag, "_n_mode_ok"}, p_mode_ok, 1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_de"}, o_de, 0);         chk({tag, "_sx"}, o_sx, 0);
      chk({tag, "_sy"}, o_sy, 0);         chk({tag, "_frame"}, o_frame, 0);
      chk({tag, "_meas"}, |{o_h_total, o_h_active, o_v_total, o_v_active}, 0);
      chk({tag, "_locked"}, o_locked, 0); chk({tag, "_mode_ok"}, o_mode_ok, 0);
      chk({tag, "_err"}, o_err, 0);
   endtask

   vec_t vt[12];

   initial begin
      // Single-cycle coordinate/frame behaviour straight out of reset.
      vt[0]  = '{0, 0, 1, 1, 0, 16'd0, 16'd0};
      vt[1]  = '{0, 0, 1, 1, 0, 16'd1, 16'd0};
      vt[2]  = '{0, 0, 1, 1, 0, 16'd2, 16'd0};
      vt[3]  = '{0, 0, 0, 0, 0, 16'd0, 16'd1};
      vt[4]  = '{0, 0, 1, 1, 0, 16'd0, 16'd1};
      vt[5]  = '{0, 0, 1, 1, 0, 16'd1, 16'd1};
      vt[6]  = '{0, 1, 0, 0, 1, 16'd0, 16'd0};  // vs edge and de fall together: vs wins
      vt[7]  = '{0, 1, 0, 0, 0, 16'd0, 16'd0};
      vt[8]  = '{0, 0, 1, 1, 0, 16'd0, 16'd0};
      vt[9]  = '{0, 0, 0, 0, 0, 16'd0, 16'd1};
      vt[10] = '{0, 1, 0, 0, 1, 16'd0, 16'd0};
      vt[11] = '{1, 0, 1, 1, 0, 16'd0, 16'd0};

      clr_mon();
      rst = 1'b1; hs = 0; vs = 0; de = 0; hs2 = 1; vs2 = 1;
      #12;
      chk_zero("rst_held");
      do_reset(1'b0);
      chk_zero("rst_rel");

      for (int i = 0; i < 12; i++) begin
         step(vt[i].hs, vt[i].vs, vt[i].de);
         chk($sformatf("vec%0d_de", i), o_de, vt[i].e_de);
         chk($sformatf("vec%0d_frame", i), o_frame, vt[i].e_fr);
         chk($sformatf("vec%0d_sx", i), o_sx, vt[i].e_sx);
         chk($sformatf("vec%0d_sy", i), o_sy, vt[i].e_sy);
      end

      // A sync already active when reset releases still counts as a leading edge.
      do_reset(1'b1);
      step(0, 1, 0);
      chk("vs_at_release_frame", o_frame, 1);
      chk("vs_at_release_frame_n", p_frame, 1);
      step(0, 1, 0);
      chk("vs_held_no_frame", o_frame, 0);

      // Lock from a clean reset: locked on the 3rd vs edge.
      do_reset(1'b0);
      clr_mon();
      frame(HT, 1); frame(HT, 1); frame(HT, 1);
      chk("lock_vs_edge", lock_vs, 3);
      chk("lock_vs_edge_n", lock2_vs, 3);
      chk("lock_no_err", err_cnt, 0);
      chk_meas("lock");

      // One frame with a longer line: error at its vs edge, relock 3 edges later.
      frame(HT, 0);
      clr_mon();
      frame(HT + 1, 0);
      chk("hchg_err_pulses", err_cnt, 1);
      chk("hchg_err_pulses_n", err2_cnt, 1);
      chk("hchg_unlocked", o_locked, 0);
      chk("hchg_mode_ok", o_mode_ok, 0);
      clr_mon();
      frame(HT, 0); frame(HT, 0); frame(HT, 0);
      chk("relock_vs_edge", lock_vs, 3);
      chk("relock_vs_edge_n", lock2_vs, 3);
      chk_meas("relock");

      // Sync loss while locked.
      clr_mon();
      for (int i = 0; i < 4300; i++) step(0, 0, 0);
      chk("timeout_err_pulses", err_cnt, 1);
      chk("timeout_err_pulses_n", err2_cnt, 1);
      chk("timeout_unlocked", o_locked, 0);
      chk("timeout_hold_h_total", o_h_total, HT);
      chk("timeout_hold_v_active", o_v_active, VA);

      // Reset asserted mid-line acts before the next edge.
      frame(HT, 0); frame(HT, 0); frame(HT, 0);
      chk("pre_rst_locked", o_locked, 1);
      for (int x = 0; x <= 18; x++) step(x < 4, 0, x >= 8);
      chk("pre_rst_sx", o_sx, 10);
      #3 rst = 1'b1;
      #1 chk_zero("async_rst");
      chk("async_rst_n_locked", p_locked, 0);
      @(posedge clk); #1 rst = 1'b0;
      clr_mon();
      frame(HT, 1); frame(HT, 1); frame(HT, 1);
      chk("post_rst_lock_vs_edge", lock_vs, 3);
      chk_meas("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
